// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : otter_pkg
//  Description : Shared types and constants for the pipelined OTTER control
//                unit: opcodes, SYSTEM funct3 encodings, interrupt FSM states.
//  Revision    : 1.0  initial release
// ============================================================================
package otter_pkg;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYSTEM = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_PRIV   = 3'b000,
    F3_CSRRW  = 3'b001,
    F3_CSRRS  = 3'b010,
    F3_CSRRC  = 3'b011,
    F3_CSRRWI = 3'b101,
    F3_CSRRSI = 3'b110,
    F3_CSRRCI = 3'b111
  } funct3_system_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    TAKE    = 2'd2,
    HANDLER = 2'd3
  } cu_state_t;

  localparam logic [11:0] MRET_FUNC12 = 12'h302;

  // True for the six CSR access forms (register and immediate variants)
  function automatic logic is_csr_f3(input logic [2:0] f3);
    return (f3 == F3_CSRRW)  || (f3 == F3_CSRRS)  || (f3 == F3_CSRRC) ||
           (f3 == F3_CSRRWI) || (f3 == F3_CSRRSI) || (f3 == F3_CSRRCI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/otter_irq_prio.sv
`default_nettype none
// ============================================================================
//  Module      : otter_irq_prio
//  Description : Fixed-priority encoder; index 0 is the highest priority.
//                Produces a valid flag, the winning index and its one-hot.
//  Revision    : 1.0  initial release
// ============================================================================
module otter_irq_prio #(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]         i_req,
  output logic                       o_valid,
  output logic [$clog2(NUM_IRQ)-1:0] o_index,
  output logic [NUM_IRQ-1:0]         o_onehot
);

  localparam int c_IDX_W = $clog2(NUM_IRQ);

  // Scan from the lowest priority upward so the lowest set index wins last
  always_comb begin
    o_valid  = |i_req;
    o_index  = '0;
    o_onehot = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_index     = c_IDX_W'(i);
        o_onehot    = '0;
        o_onehot[i] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/otter_pipe_cu.sv
`default_nettype none
// ============================================================================
//  Module      : otter_pipe_cu
//  Description : Decode-stage control for the 5-stage cached OTTER. Opcode
//                decode, load-use / branch / cache-miss hazard control and a
//                drain-then-take interrupt sequencer with no nesting.
//  Revision    : 1.0  initial release
// ============================================================================
module otter_pipe_cu
  import otter_pkg::*;
#(
  parameter int NUM_IRQ      = 4,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                       CU_CLK,
  input  logic                       CU_RESET,
  input  logic [6:0]                 CU_OPCODE,
  input  logic [2:0]                 CU_FUNC3,
  input  logic [11:0]                CU_FUNC12,
  input  logic [4:0]                 CU_RS1,
  input  logic [4:0]                 CU_RS2,
  input  logic [4:0]                 CU_EX_RD,
  input  logic                       CU_EX_MEMREAD,
  input  logic                       CU_BR_TAKEN,
  input  logic                       CU_MEM_STALL,
  input  logic [NUM_IRQ-1:0]         CU_IRQ,
  input  logic                       CU_MIE,
  output logic                       CU_REGWRITE,
  output logic                       CU_MEMWRITE,
  output logic                       CU_MEMREAD2,
  output logic                       CU_csrWrite,
  output logic                       CU_MRET,
  output logic                       CU_STALL_PC,
  output logic                       CU_STALL_IFDE,
  output logic                       CU_BUBBLE_DE,
  output logic                       CU_FLUSH_IFDE,
  output logic                       CU_intTaken,
  output logic [$clog2(NUM_IRQ)-1:0] CU_intCAUSE,
  output logic [NUM_IRQ-1:0]         CU_intCLR
);

  localparam int c_IDX_W = $clog2(NUM_IRQ);
  localparam int c_CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LOAD =
      c_CNT_W'((DRAIN_CYCLES > 0) ? (DRAIN_CYCLES - 1) : 0);

  cu_state_t            r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [c_IDX_W-1:0]   r_cause;      // cause latched when the IRQ is accepted
  logic [c_IDX_W-1:0]   r_cause_out;  // cause of the most recent completed take
  logic [NUM_IRQ-1:0]   r_clr;

  logic                 w_prio_valid;
  logic [c_IDX_W-1:0]   w_prio_idx;
  logic [NUM_IRQ-1:0]   w_prio_oh;
  logic [NUM_IRQ-1:0]   w_pending;

  logic w_is_branch, w_is_store, w_is_load, w_is_system;
  logic w_dec_mret, w_loaduse, w_take, w_bubble;

  assign w_pending = CU_IRQ & {NUM_IRQ{CU_MIE}};

  otter_irq_prio #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio (
    .i_req    (w_pending),
    .o_valid  (w_prio_valid),
    .o_index  (w_prio_idx),
    .o_onehot (w_prio_oh)
  );

  assign w_is_branch = (CU_OPCODE == OP_BRANCH);
  assign w_is_store  = (CU_OPCODE == OP_STORE);
  assign w_is_load   = (CU_OPCODE == OP_LOAD);
  assign w_is_system = (CU_OPCODE == OP_SYSTEM);
  assign w_dec_mret  = w_is_system && (CU_FUNC3 == F3_PRIV) && (CU_FUNC12 == MRET_FUNC12);
  assign w_loaduse   = CU_EX_MEMREAD && (CU_EX_RD != 5'd0) &&
                       ((CU_EX_RD == CU_RS1) || (CU_EX_RD == CU_RS2));
  assign w_take      = (r_state == TAKE);

  // Hazard arbitration: cache miss, then trap flush, then branch, then stall sources
  always_comb begin
    CU_STALL_PC   = 1'b0;
    CU_STALL_IFDE = 1'b0;
    w_bubble      = 1'b0;
    CU_FLUSH_IFDE = 1'b0;
    if (CU_MEM_STALL) begin
      CU_STALL_PC   = 1'b1;
      CU_STALL_IFDE = 1'b1;
    end else if (w_take || CU_BR_TAKEN) begin
      CU_FLUSH_IFDE = 1'b1;
      w_bubble      = 1'b1;
    end else if ((r_state == DRAIN) || w_loaduse) begin
      CU_STALL_PC   = 1'b1;
      CU_STALL_IFDE = 1'b1;
      w_bubble      = 1'b1;
    end
  end

  assign CU_BUBBLE_DE = w_bubble;

  // Decode controls are suppressed whenever DE/EX receives a NOP
  assign CU_REGWRITE = !w_bubble && !w_is_branch && !w_is_store;
  assign CU_MEMWRITE = !w_bubble && w_is_store;
  assign CU_MEMREAD2 = !w_bubble && w_is_load;
  assign CU_csrWrite = !w_bubble && w_is_system && is_csr_f3(CU_FUNC3);
  assign CU_MRET     = !w_bubble && w_dec_mret;

  // Trap outputs; a cache miss holds the take until the pipe can move
  assign CU_intTaken = w_take && !CU_MEM_STALL;
  assign CU_intCAUSE = w_take ? r_cause : r_cause_out;
  assign CU_intCLR   = CU_intTaken ? r_clr : '0;

  // Interrupt sequencer; everything freezes while the cache is missing
  always_ff @(posedge CU_CLK) begin
    if (CU_RESET) begin
      r_state     <= RUN;
      r_cnt       <= '0;
      r_cause     <= '0;
      r_cause_out <= '0;
      r_clr       <= '0;
    end else if (!CU_MEM_STALL) begin
      case (r_state)
        RUN: begin
          if (w_prio_valid) begin
            r_cause <= w_prio_idx;
            r_clr   <= w_prio_oh;
            if (DRAIN_CYCLES == 0) begin
              r_state <= TAKE;
            end else begin
              r_state <= DRAIN;
              r_cnt   <= c_CNT_LOAD;
            end
          end
        end
        DRAIN: begin
          if (r_cnt == '0) begin
            r_state <= TAKE;
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        TAKE: begin
          r_cause_out <= r_cause;
          r_state     <= HANDLER;
        end
        HANDLER: begin
          if (w_dec_mret && !w_bubble) begin
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_otter_pipe_cu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_otter_pipe_cu
//  Description : Directed self-checking bench for otter_pipe_cu
//                (NUM_IRQ = 4, DRAIN_CYCLES = 3).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_otter_pipe_cu;
  import otter_pkg::*;

  logic        CU_CLK = 1'b0;
  logic        CU_RESET;
  logic [6:0]  CU_OPCODE;
  logic [2:0]  CU_FUNC3;
  logic [11:0] CU_FUNC12;
  logic [4:0]  CU_RS1, CU_RS2, CU_EX_RD;
  logic        CU_EX_MEMREAD, CU_BR_TAKEN, CU_MEM_STALL, CU_MIE;
  logic [3:0]  CU_IRQ;
  logic        CU_REGWRITE, CU_MEMWRITE, CU_MEMREAD2, CU_csrWrite, CU_MRET;
  logic        CU_STALL_PC, CU_STALL_IFDE, CU_BUBBLE_DE, CU_FLUSH_IFDE;
  logic        CU_intTaken;
  logic [1:0]  CU_intCAUSE;
  logic [3:0]  CU_intCLR;

  int n_vec = 0;
  int n_err = 0;

  otter_pipe_cu #(
    .NUM_IRQ      (4),
    .DRAIN_CYCLES (3)
  ) dut (
    .CU_CLK        (CU_CLK),
    .CU_RESET      (CU_RESET),
    .CU_OPCODE     (CU_OPCODE),
    .CU_FUNC3      (CU_FUNC3),
    .CU_FUNC12     (CU_FUNC12),
    .CU_RS1        (CU_RS1),
    .CU_RS2        (CU_RS2),
    .CU_EX_RD      (CU_EX_RD),
    .CU_EX_MEMREAD (CU_EX_MEMREAD),
    .CU_BR_TAKEN   (CU_BR_TAKEN),
    .CU_MEM_STALL  (CU_MEM_STALL),
    .CU_IRQ        (CU_IRQ),
    .CU_MIE        (CU_MIE),
    .CU_REGWRITE   (CU_REGWRITE),
    .CU_MEMWRITE   (CU_MEMWRITE),
    .CU_MEMREAD2   (CU_MEMREAD2),
    .CU_csrWrite   (CU_csrWrite),
    .CU_MRET       (CU_MRET),
    .CU_STALL_PC   (CU_STALL_PC),
    .CU_STALL_IFDE (CU_STALL_IFDE),
    .CU_BUBBLE_DE  (CU_BUBBLE_DE),
    .CU_FLUSH_IFDE (CU_FLUSH_IFDE),
    .CU_intTaken   (CU_intTaken),
    .CU_intCAUSE   (CU_intCAUSE),
    .CU_intCLR     (CU_intCLR)
  );

  always #5 CU_CLK = ~CU_CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CU_CLK);
    #1;
  endtask

  task automatic idle();
    CU_OPCODE     = OP_IMM;
    CU_FUNC3      = 3'b000;
    CU_FUNC12     = 12'h000;
    CU_RS1        = 5'd0;
    CU_RS2        = 5'd0;
    CU_EX_RD      = 5'd0;
    CU_EX_MEMREAD = 1'b0;
    CU_BR_TAKEN   = 1'b0;
    CU_MEM_STALL  = 1'b0;
    CU_IRQ        = 4'b0000;
    CU_MIE        = 1'b0;
  endtask

  task automatic set_mret();
    CU_OPCODE = OP_SYSTEM;
    CU_FUNC3  = 3'b000;
    CU_FUNC12 = 12'h302;
  endtask

  initial begin
    idle();
    CU_RESET = 1'b1;
    tick();
    tick();
    // State after reset
    check("rst_intTaken", CU_intTaken, 0);
    check("rst_intCAUSE", CU_intCAUSE, 0);
    check("rst_intCLR",   CU_intCLR,   0);
    check("rst_stall_pc", CU_STALL_PC, 0);
    check("rst_bubble",   CU_BUBBLE_DE, 0);
    CU_RESET = 1'b0;

    // Load-use on RS1
    tick();
    CU_OPCODE = OP_REG; CU_EX_MEMREAD = 1'b1; CU_EX_RD = 5'd5; CU_RS1 = 5'd5;
    #1;
    check("lu_stall_pc",   CU_STALL_PC,   1);
    check("lu_stall_ifde", CU_STALL_IFDE, 1);
    check("lu_bubble",     CU_BUBBLE_DE,  1);
    check("lu_regwrite",   CU_REGWRITE,   0);
    // x0 destination never stalls
    CU_EX_RD = 5'd0; CU_RS1 = 5'd0;
    #1;
    check("lu_x0_stall",    CU_STALL_PC, 0);
    check("lu_x0_regwrite", CU_REGWRITE, 1);

    // Branch beats load-use (match on RS2)
    tick();
    CU_EX_RD = 5'd5; CU_RS2 = 5'd5; CU_BR_TAKEN = 1'b1;
    #1;
    check("br_flush",    CU_FLUSH_IFDE, 1);
    check("br_bubble",   CU_BUBBLE_DE,  1);
    check("br_stall_pc", CU_STALL_PC,   0);

    // Decode table
    tick();
    idle();
    CU_OPCODE = OP_STORE;
    #1;
    check("st_memwrite", CU_MEMWRITE, 1);
    check("st_regwrite", CU_REGWRITE, 0);
    CU_OPCODE = OP_LOAD;
    #1;
    check("ld_memread", CU_MEMREAD2, 1);
    check("ld_regwrite", CU_REGWRITE, 1);
    tick();
    CU_OPCODE = OP_SYSTEM; CU_FUNC3 = 3'b110; CU_FUNC12 = 12'h302;
    #1;
    check("csrrsi_csrwrite", CU_csrWrite, 1);
    check("csrrsi_mret",     CU_MRET,     0);
    set_mret();
    #1;
    check("mret_dec",     CU_MRET,     1);
    check("mret_csr",     CU_csrWrite, 0);

    // MIE clear masks every source
    tick();
    idle();
    CU_IRQ = 4'b1111; CU_MIE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mie0_taken", CU_intTaken, 0);
      check("mie0_stall", CU_STALL_PC, 0);
      check("mie0_clr",   CU_intCLR,   0);
    end

    // IRQ[2] and IRQ[1] together: source 1 first
    idle();
    tick();
    CU_IRQ = 4'b0110; CU_MIE = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("drain_stall",  CU_STALL_PC,  1);
      check("drain_bubble", CU_BUBBLE_DE, 1);
      check("drain_taken",  CU_intTaken,  0);
      tick();
    end
    check("take1_taken", CU_intTaken,   1);
    check("take1_cause", CU_intCAUSE,   1);
    check("take1_clr",   CU_intCLR,     4'b0010);
    check("take1_flush", CU_FLUSH_IFDE, 1);
    CU_IRQ = 4'b0100;
    tick();
    check("hdl_taken", CU_intTaken, 0);
    check("hdl_stall", CU_STALL_PC, 0);
    check("hdl_cause", CU_intCAUSE, 1);
    tick();
    check("hdl_nest", CU_intTaken, 0);
    set_mret();
    #1;
    check("hdl_mret", CU_MRET, 1);
    tick();
    CU_OPCODE = OP_IMM; CU_FUNC12 = 12'h000;
    #1;
    check("run_after_mret", CU_STALL_PC, 0);
    tick();
    check("drain2_stall", CU_STALL_PC, 1);
    check("drain2_cause", CU_intCAUSE, 1);
    tick();
    tick();
    tick();
    check("take2_taken", CU_intTaken, 1);
    check("take2_cause", CU_intCAUSE, 2);
    check("take2_clr",   CU_intCLR,   4'b0100);
    CU_IRQ = 4'b0000;
    tick();
    set_mret();
    tick();
    idle();

    // Cache miss for two cycles mid-drain delays the take by two
    tick();
    CU_IRQ = 4'b0001; CU_MIE = 1'b1;
    tick();
    tick();
    CU_MEM_STALL = 1'b1;
    #1;
    check("ms_stall_pc", CU_STALL_PC,  1);
    check("ms_bubble",   CU_BUBBLE_DE, 0);
    check("ms_taken_a",  CU_intTaken,  0);
    tick();
    check("ms_taken_b",  CU_intTaken,  0);
    tick();
    CU_MEM_STALL = 1'b0;
    #1;
    check("ms_taken_c",  CU_intTaken,  0);
    tick();
    check("ms_taken_d",  CU_intTaken,  0);
    check("ms_drain",    CU_STALL_PC,  1);
    tick();
    check("ms_take",     CU_intTaken,  1);
    check("ms_cause",    CU_intCAUSE,  0);
    check("ms_clr",      CU_intCLR,    4'b0001);
    CU_IRQ = 4'b0000;

    // Reset in HANDLER, then a fresh IRQ is taken normally
    tick();
    check("hdl3_stall", CU_STALL_PC, 0);
    CU_RESET = 1'b1;
    CU_IRQ   = 4'b1000;
    tick();
    CU_RESET = 1'b0;
    #1;
    check("rst2_taken", CU_intTaken,   0);
    check("rst2_cause", CU_intCAUSE,   0);
    check("rst2_clr",   CU_intCLR,     0);
    check("rst2_stall", CU_STALL_PC,   0);
    check("rst2_flush", CU_FLUSH_IFDE, 0);
    tick();
    check("rst2_drain", CU_STALL_PC, 1);
    tick();
    tick();
    tick();
    check("take3_taken", CU_intTaken, 1);
    check("take3_cause", CU_intCAUSE, 3);
    check("take3_clr",   CU_intCLR,   4'b1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
